// File: rtl/jk_down_count_monitor_if.sv
// rtl/jk_down_count_monitor_if.sv - counter sample in, phase/lock/error status out
interface jk_down_count_monitor_if #(
    parameter int WRAP_W = 8,
    parameter int ERR_W  = 4
);
    logic              clr;
    logic [1:0]        cnt_in;
    logic [3:0]        phase;
    logic              tc;
    logic [WRAP_W-1:0] wrap_cnt;
    logic              locked;
    logic              err;
    logic [ERR_W-1:0]  err_cnt;

    modport master (
        output clr, cnt_in,
        input  phase, tc, wrap_cnt, locked, err, err_cnt
    );

    modport slave (
        input  clr, cnt_in,
        output phase, tc, wrap_cnt, locked, err, err_cnt
    );
endinterface

// File: rtl/jk_down_count_monitor.sv
// rtl/jk_down_count_monitor.sv - checks a 2-bit down counter, locks onto it, emits phase strobes and tc
module jk_down_count_monitor #(
    parameter int WRAP_W   = 8,
    parameter int LOCK_CNT = 4,
    parameter int ERR_W    = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    jk_down_count_monitor_if.slave   bus
);
    localparam int RUN_W = (LOCK_CNT > 1) ? $clog2(LOCK_CNT) : 1;
    localparam logic [RUN_W-1:0] RUN_LAST = RUN_W'(LOCK_CNT - 1);

    typedef enum logic [1:0] {IDLE, ACQUIRE, LOCKED, FAULT} state_t;

    state_t            state_q, state_d;
    logic [RUN_W-1:0]  run_q, run_d;
    logic [1:0]        prev_q, prev_d;
    logic              prev_vld_q, prev_vld_d;
    logic [3:0]        phase_q, phase_d;
    logic              tc_q, tc_d;
    logic [WRAP_W-1:0] wrap_cnt_q, wrap_cnt_d;
    logic              locked_q, locked_d;
    logic              err_q, err_d;
    logic [ERR_W-1:0]  err_cnt_q, err_cnt_d;
    logic              good;
    logic [1:0]        prev_dec;

    assign prev_dec = prev_q - 2'd1;
    assign good     = prev_vld_q && (bus.cnt_in == prev_dec);

    always_comb begin
        state_d    = state_q;
        run_d      = run_q;
        prev_d     = bus.cnt_in;
        prev_vld_d = 1'b1;
        phase_d    = 4'b0001 << bus.cnt_in;
        // a good transition out of 01 can only land on 00
        tc_d       = good && (prev_q == 2'b01);
        wrap_cnt_d = wrap_cnt_q;
        err_d      = err_q;
        err_cnt_d  = err_cnt_q;

        if (tc_d && state_q == LOCKED) begin
            wrap_cnt_d = wrap_cnt_q + WRAP_W'(1);
        end

        case (state_q)
            IDLE: begin
                state_d = ACQUIRE;
                run_d   = '0;
            end
            ACQUIRE: begin
                if (!good) begin
                    run_d = '0;
                end else if (run_q == RUN_LAST) begin
                    state_d = LOCKED;
                    run_d   = '0;
                end else begin
                    run_d = run_q + RUN_W'(1);
                end
            end
            LOCKED: begin
                if (!good) begin
                    state_d = FAULT;
                    err_d   = 1'b1;
                    if (err_cnt_q != '1) err_cnt_d = err_cnt_q + ERR_W'(1);
                end
            end
            FAULT: begin
                if (good) begin
                    state_d = (LOCK_CNT == 1) ? LOCKED : ACQUIRE;
                    run_d   = (LOCK_CNT == 1) ? '0 : RUN_W'(1);
                end else if (err_cnt_q != '1) begin
                    err_cnt_d = err_cnt_q + ERR_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        locked_d = (state_d == LOCKED);

        if (bus.clr) begin
            state_d    = IDLE;
            run_d      = '0;
            prev_d     = '0;
            prev_vld_d = 1'b0;
            phase_d    = '0;
            tc_d       = 1'b0;
            wrap_cnt_d = '0;
            locked_d   = 1'b0;
            err_d      = 1'b0;
            err_cnt_d  = '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            run_q      <= '0;
            prev_q     <= '0;
            prev_vld_q <= 1'b0;
            phase_q    <= '0;
            tc_q       <= 1'b0;
            wrap_cnt_q <= '0;
            locked_q   <= 1'b0;
            err_q      <= 1'b0;
            err_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            run_q      <= run_d;
            prev_q     <= prev_d;
            prev_vld_q <= prev_vld_d;
            phase_q    <= phase_d;
            tc_q       <= tc_d;
            wrap_cnt_q <= wrap_cnt_d;
            locked_q   <= locked_d;
            err_q      <= err_d;
            err_cnt_q  <= err_cnt_d;
        end
    end

    assign bus.phase    = phase_q;
    assign bus.tc       = tc_q;
    assign bus.wrap_cnt = wrap_cnt_q;
    assign bus.locked   = locked_q;
    assign bus.err      = err_q;
    assign bus.err_cnt  = err_cnt_q;
endmodule

// File: tb/tb_jk_down_count_monitor.sv
// tb/tb_jk_down_count_monitor.sv - scoreboard bench for jk_down_count_monitor
module tb_jk_down_count_monitor;
    localparam int WRAP_W   = 2;
    localparam int LOCK_CNT = 4;
    localparam int ERR_W    = 2;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail = 0;

    typedef struct {
        int         cyc;
        logic [3:0] phase;
        logic       tc;
        logic [1:0] wrap;
        logic       locked;
        logic       err;
        logic [1:0] ec;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;

    jk_down_count_monitor_if #(.WRAP_W(WRAP_W), .ERR_W(ERR_W)) intf ();

    jk_down_count_monitor #(.WRAP_W(WRAP_W), .LOCK_CNT(LOCK_CNT), .ERR_W(ERR_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (intf.slave)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input int at, input logic [7:0] act, input logic [7:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @cycle %0d: got %0h expected %0h", nm, at, act, exp);
        end
    endtask

    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].cyc < cyc) begin
            mon_e = sb.pop_front();
            chk("missed_expectation", mon_e.cyc, 8'd1, 8'd0);
        end
        if (sb.size() > 0 && sb[0].cyc == cyc) begin
            mon_e = sb.pop_front();
            chk("phase",    cyc, {4'b0, intf.phase},    {4'b0, mon_e.phase});
            chk("tc",       cyc, {7'b0, intf.tc},       {7'b0, mon_e.tc});
            chk("wrap_cnt", cyc, {6'b0, intf.wrap_cnt}, {6'b0, mon_e.wrap});
            chk("locked",   cyc, {7'b0, intf.locked},   {7'b0, mon_e.locked});
            chk("err",      cyc, {7'b0, intf.err},      {7'b0, mon_e.err});
            chk("err_cnt",  cyc, {6'b0, intf.err_cnt},  {6'b0, mon_e.ec});
        end
    end

    task automatic step(input logic c, input logic [1:0] v, input logic [3:0] ph, input logic t,
                        input logic [1:0] w, input logic l, input logic e, input logic [1:0] ec);
        intf.clr    = c;
        intf.cnt_in = v;
        sb.push_back('{cyc + 1, ph, t, w, l, e, ec});
        @(posedge clk);
        #2;
    endtask

    task automatic chk_all_zero(input string nm);
        chk({nm, "_phase"},    cyc, {4'b0, intf.phase},    8'd0);
        chk({nm, "_tc"},       cyc, {7'b0, intf.tc},       8'd0);
        chk({nm, "_wrap_cnt"}, cyc, {6'b0, intf.wrap_cnt}, 8'd0);
        chk({nm, "_locked"},   cyc, {7'b0, intf.locked},   8'd0);
        chk({nm, "_err"},      cyc, {7'b0, intf.err},      8'd0);
        chk({nm, "_err_cnt"},  cyc, {6'b0, intf.err_cnt},  8'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0] wtab [5];
        logic [1:0] wprev;
        logic [1:0] up;
        logic [3:0] one_hot;
        wtab = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
        intf.clr    = 1'b0;
        intf.cnt_in = 2'b00;
        repeat (2) @(negedge clk);
        chk_all_zero("reset");
        reset = 1'b0;

        // lock then count wraps
        step(0, 2'b00, 4'b0001, 0, 0, 0, 0, 0);
        step(0, 2'b11, 4'b1000, 0, 0, 0, 0, 0);
        step(0, 2'b10, 4'b0100, 0, 0, 0, 0, 0);
        step(0, 2'b01, 4'b0010, 0, 0, 0, 0, 0);
        step(0, 2'b00, 4'b0001, 1, 0, 1, 0, 0);
        step(0, 2'b11, 4'b1000, 0, 0, 1, 0, 0);
        step(0, 2'b10, 4'b0100, 0, 0, 1, 0, 0);
        step(0, 2'b01, 4'b0010, 0, 0, 1, 0, 0);
        step(0, 2'b00, 4'b0001, 1, 1, 1, 0, 0);
        // stuck fault and reacquire
        step(0, 2'b11, 4'b1000, 0, 1, 1, 0, 0);
        step(0, 2'b10, 4'b0100, 0, 1, 1, 0, 0);
        step(0, 2'b10, 4'b0100, 0, 1, 0, 1, 1);
        step(0, 2'b01, 4'b0010, 0, 1, 0, 1, 1);
        step(0, 2'b00, 4'b0001, 1, 1, 0, 1, 1);
        step(0, 2'b11, 4'b1000, 0, 1, 0, 1, 1);
        step(0, 2'b10, 4'b0100, 0, 1, 1, 1, 1);
        // clr while locked with err set, also a stuck sample
        step(1, 2'b10, 4'b0000, 0, 0, 0, 0, 0);
        step(0, 2'b11, 4'b1000, 0, 0, 0, 0, 0);
        step(0, 2'b10, 4'b0100, 0, 0, 0, 0, 0);
        step(0, 2'b01, 4'b0010, 0, 0, 0, 0, 0);
        step(0, 2'b00, 4'b0001, 1, 0, 0, 0, 0);
        step(0, 2'b11, 4'b1000, 0, 0, 1, 0, 0);
        // wrap rollover over five full cycles
        for (int k = 0; k < 5; k++) begin
            wprev = (k == 0) ? 2'd0 : wtab[k-1];
            step(0, 2'b10, 4'b0100, 0, wprev,   1, 0, 0);
            step(0, 2'b01, 4'b0010, 0, wprev,   1, 0, 0);
            step(0, 2'b00, 4'b0001, 1, wtab[k], 1, 0, 0);
            step(0, 2'b11, 4'b1000, 0, wtab[k], 1, 0, 0);
        end
        // error saturation
        step(0, 2'b11, 4'b1000, 0, 1, 0, 1, 1);
        step(0, 2'b00, 4'b0001, 0, 1, 0, 1, 2);
        step(0, 2'b01, 4'b0010, 0, 1, 0, 1, 3);
        step(0, 2'b11, 4'b1000, 0, 1, 0, 1, 3);
        step(0, 2'b11, 4'b1000, 0, 1, 0, 1, 3);
        step(0, 2'b01, 4'b0010, 0, 1, 0, 1, 3);
        // clear, relock, then clr coincident with a bad sample
        step(1, 2'b10, 4'b0000, 0, 0, 0, 0, 0);
        step(0, 2'b00, 4'b0001, 0, 0, 0, 0, 0);
        step(0, 2'b11, 4'b1000, 0, 0, 0, 0, 0);
        step(0, 2'b10, 4'b0100, 0, 0, 0, 0, 0);
        step(0, 2'b01, 4'b0010, 0, 0, 0, 0, 0);
        step(0, 2'b00, 4'b0001, 1, 0, 1, 0, 0);
        step(1, 2'b00, 4'b0000, 0, 0, 0, 0, 0);
        step(0, 2'b11, 4'b1000, 0, 0, 0, 0, 0);
        step(0, 2'b10, 4'b0100, 0, 0, 0, 0, 0);
        step(0, 2'b01, 4'b0010, 0, 0, 0, 0, 0);
        step(0, 2'b00, 4'b0001, 1, 0, 0, 0, 0);
        step(0, 2'b11, 4'b1000, 0, 0, 1, 0, 0);
        // async reset between edges while locked
        @(negedge clk);
        chk("pre_reset_locked", cyc, {7'b0, intf.locked}, 8'd1);
        #1;
        reset = 1'b1;
        #1;
        chk_all_zero("async_reset");
        @(negedge clk);
        reset = 1'b0;
        // up-counting input never locks
        for (int k = 0; k < 12; k++) begin
            up = 2'(k);
            one_hot = 4'b0001 << up;
            step(0, up, one_hot, 0, 0, 0, 0, 0);
        end
        @(negedge clk);
        #1;
        chk("scoreboard_drained", cyc, 8'(sb.size()), 8'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/jk_down_count_monitor.md
# jk_down_count_monitor

Downstream consumer of the 2-bit synchronous JK down counter: samples its count every clock, checks that it follows the legal down sequence, and produces registered one-hot phase enables and a terminal-count pulse. A lock state machine qualifies the counter before its wraps are counted. Errors after lock are flagged and counted. The block sits between the counter and any logic that needs phase strobes or a cycle-period tick.

## Interface
- `WRAP_W`, default 8: width of the wrap counter.
- `LOCK_CNT`, default 4: consecutive legal transitions required to lock. Legal range is ≥1.
- `ERR_W`, default 4: width of the saturating error counter.

- `clk`  input  1: rising-edge clock, the only clock.
- `reset`  input  1: asynchronous, active-high reset.
- `clr`  input  1: synchronous clear. Same effect as reset, applied at the clock edge.
- `cnt_in`  input  2: counter value, sampled every edge.
- `phase`  output  4: registered one-hot decode of `cnt_in`.
- `tc`  output  1: registered one-cycle terminal-count pulse.
- `wrap_cnt`  output  WRAP_W: completed wraps counted while locked.
- `locked`  output  1: high while the FSM is in LOCKED.
- `err`  output  1: sticky fault flag.
- `err_cnt`  output  ERR_W: saturating count of illegal transitions seen in LOCKED or FAULT.

## Operation
- Legal sequence: 00→11→10→01→00. A transition is "good" when `cnt_in == prev − 1 (mod 4)`. Any other value is "bad", including a repeated value (stuck counter).
- `prev` is a register loaded with `cnt_in` on every edge. `prev_vld` goes high on the first edge after reset or clr.
- `phase[k]` is 1 iff the sampled `cnt_in == k`.
- `tc` is 1 for one cycle after a good 01→00 transition, independent of lock state.
- `wrap_cnt` increments on an edge where the tc condition holds **and** the state is LOCKED. It wraps modulo 2^WRAP_W.
- FSM states: IDLE, ACQUIRE, LOCKED, FAULT. A run counter `run` counts consecutive good transitions.
  - IDLE: capture `prev`, then go to ACQUIRE with `run` = 0. No check is made on this edge.
  - ACQUIRE, good transition:
    - If `run` = LOCK_CNT−1, go to LOCKED.
    - Otherwise `run`++.
  - ACQUIRE, bad transition: `run` = 0, stay in ACQUIRE. Neither `err` nor `err_cnt` changes.
  - LOCKED, good transition: stay in LOCKED.
  - LOCKED, bad transition: go to FAULT, set `err`, increment `err_cnt`.
  - FAULT, bad transition: stay in FAULT, increment `err_cnt`.
  - FAULT, good transition: go to ACQUIRE with `run` = 1. If LOCK_CNT = 1, go directly to LOCKED.
- `err_cnt` saturates at all-ones and never wraps.
- `err` is cleared only by reset or clr.
- `locked` is decoded from the state register. It is never combinational from `cnt_in`.

## Timing
- Reset values:
  - `phase` = 0000, `tc` = 0, `wrap_cnt` = 0.
  - `locked` = 0, `err` = 0, `err_cnt` = 0.
  - Internal: state = IDLE, `run` = 0, `prev_vld` = 0.
- `phase`, `tc` and the FSM update one edge after the `cnt_in` sample that causes them.
- Lock latency from reset release with continuous legal input: one IDLE edge plus LOCK_CNT good edges. `locked` rises after edge LOCK_CNT+1.
- Failure response: `err` and `err_cnt` update, and `locked` falls, on the same edge that samples the bad value.
- If `reset` asserts mid-operation, all registers return to reset values immediately, with no clock needed.
- `clr` high at an edge loads reset values and takes priority over every other update on that edge. `reset` overrides `clr`.
- When `clr` deasserts, the next edge is treated as IDLE.

## Test plan
- **Lock and wrap counting** (LOCK_CNT=4). Release reset and drive 00,11,10,01,00,11,10,01,00.
  - `locked` = 1 after edge 5.
  - `tc` pulses after edge 5 and again after edge 9.
  - `wrap_cnt` = 0 after edge 5, and 1 after edge 9. The first tc is not counted because the state was still ACQUIRE on that edge.
  - `phase` tracks the input one cycle late, e.g. 1000 after 11 is sampled.
- **Stuck fault and reacquire.** While LOCKED, drive 10 then 10 again.
  - `locked` → 0, `err` = 1, `err_cnt` = 1.
  - Then drive 01,00,11,10: `locked` returns after the fourth good transition, and `err` stays 1.
- **Up-counting input.** Drive 00,01,10,11 repeatedly.
  - `locked` never rises, `err` stays 0, `tc` never pulses.
- **Wrap rollover** (WRAP_W=2). While locked, run 5 full cycles.
  - `wrap_cnt` sequence: 1,2,3,0,1.
- **Error saturation** (ERR_W=2). Enter FAULT, then apply 5 bad transitions.
  - `err_cnt` = 3 and holds.
- **Reset and clear.**
  - Assert `reset` between edges while LOCKED: all outputs are 0 immediately.
  - Assert `clr` for one edge while LOCKED with `err` = 1: all outputs are 0 after that edge.
  - `clr` and a bad transition on the same edge: clear wins and `err` stays 0.
